// File: rtl/acc_sequencer_if.sv
// acc_sequencer_if: handshake, control and status bundle between host/source/datapath and the sequencer.
interface acc_sequencer_if;
    logic       Start;
    logic       Data_Valid;
    logic       Count_Reg_judge;
    logic [4:0] ACC_Ctrl;
    logic       Data_Ready;
    logic       Busy;
    logic       Done;
    logic       Err;
    modport master (
        output Start, Data_Valid, Count_Reg_judge,
        input  ACC_Ctrl, Data_Ready, Busy, Done, Err
    );
    modport slave (
        input  Start, Data_Valid, Count_Reg_judge,
        output ACC_Ctrl, Data_Ready, Busy, Done, Err
    );
endinterface

// File: rtl/acc_sequencer.sv
// acc_sequencer: control FSM that loads an element count, then accumulates that many words into the datapath.
module acc_sequencer #(
    parameter int TIMEOUT_CYC = 0,
    parameter int TMO_W       = 16
) (
    input logic           Clk,
    input logic           Reset,
    acc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLR, LDCNT, CHK, ADD, DEC, DONE, ABORT} state_t;
    localparam logic [4:0] C_HOLD = 5'b11000;
    localparam logic [4:0] C_CLR  = 5'b00000;
    localparam logic [4:0] C_LDC  = 5'b10110;
    localparam logic [4:0] C_ADD  = 5'b01111;
    localparam logic [4:0] C_DEC  = 5'b10100;
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC - 1);
    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo;
    logic             wait_st, stall, tmo_hit;
    assign wait_st = state == LDCNT || state == ADD;
    assign stall   = wait_st && !bus.Data_Valid;
    // Abort decided on the last allowed stalled cycle; a word arriving then still wins.
    assign tmo_hit = (TIMEOUT_CYC != 0) && stall && tmo == TMO_LIM;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            tmo   <= '0;
        end else begin
            state <= state_nxt;
            tmo   <= stall ? tmo + 1'b1 : '0;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.Start ? CLR : IDLE;
            CLR:     state_nxt = LDCNT;
            LDCNT:   state_nxt = bus.Data_Valid ? CHK : tmo_hit ? ABORT : LDCNT;
            CHK:     state_nxt = bus.Count_Reg_judge ? ADD : DONE;
            ADD:     state_nxt = bus.Data_Valid ? DEC : tmo_hit ? ABORT : ADD;
            DEC:     state_nxt = CHK;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.Data_Ready = wait_st;
        bus.Busy       = state != IDLE;
        bus.Done       = state == DONE;
        bus.Err        = state == ABORT;
        bus.ACC_Ctrl   = state == CLR ? C_CLR :
                         state == DEC ? C_DEC :
                         !bus.Data_Valid ? C_HOLD :
                         state == LDCNT ? C_LDC :
                         state == ADD ? C_ADD : C_HOLD;
    end
endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: directed jobs on two sequencers (timeout off / 4) with a datapath model and a scoreboard monitor.
module tb_acc_sequencer;
    localparam logic [4:0] C_HOLD = 5'b11000;
    localparam logic [4:0] C_CLR  = 5'b00000;
    localparam logic [4:0] C_LDC  = 5'b10110;
    localparam logic [4:0] C_ADD  = 5'b01111;
    localparam logic [4:0] C_DEC  = 5'b10100;
    typedef struct {
        int         inst;
        bit         is_err;
        logic [7:0] sum;
        int         lat;
        int         hs;
    } exp_t;
    logic       Clk = 0;
    logic       Reset = 1;
    logic       sel = 0, start = 0, valid = 0, armed = 0;
    logic [7:0] data = 0;
    logic [7:0] cnt_m[2], acc_m[2];
    logic [4:0] ctrl[2];
    logic [1:0] rdy, vld, busy, done, err;
    logic [7:0] words[$];
    exp_t       sb[$];
    exp_t       e;
    int         compared = 0, failed = 0;
    int         bcnt[2] = '{0, 0};
    int         hcnt[2] = '{0, 0};
    always #5 Clk = ~Clk;
    acc_sequencer_if a_if();
    acc_sequencer_if b_if();
    assign a_if.Start      = !sel && start;
    assign a_if.Data_Valid = !sel && valid;
    assign b_if.Start      = sel && start;
    assign b_if.Data_Valid = sel && valid;
    assign a_if.Count_Reg_judge = cnt_m[0] != 8'd0;
    assign b_if.Count_Reg_judge = cnt_m[1] != 8'd0;
    assign ctrl[0] = a_if.ACC_Ctrl;
    assign ctrl[1] = b_if.ACC_Ctrl;
    assign rdy  = {b_if.Data_Ready, a_if.Data_Ready};
    assign vld  = {b_if.Data_Valid, a_if.Data_Valid};
    assign busy = {b_if.Busy, a_if.Busy};
    assign done = {b_if.Done, a_if.Done};
    assign err  = {b_if.Err, a_if.Err};
    acc_sequencer #(.TIMEOUT_CYC(0)) dut_a (.Clk(Clk), .Reset(Reset), .bus(a_if));
    acc_sequencer #(.TIMEOUT_CYC(4)) dut_b (.Clk(Clk), .Reset(Reset), .bus(b_if));
    // Behavioural datapath: Count_Reg and ACC_Out driven by the control word, no reset.
    always @(posedge Clk)
        for (int i = 0; i < 2; i++)
            case (ctrl[i])
                C_CLR: begin cnt_m[i] <= 8'd0; acc_m[i] <= 8'd0; end
                C_LDC: cnt_m[i] <= cnt_m[i] + data;
                C_ADD: acc_m[i] <= acc_m[i] + data;
                C_DEC: cnt_m[i] <= cnt_m[i] + 8'hFF;
                default: ;
            endcase
    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask
    function automatic int legal(input logic [4:0] c);
        return int'(c inside {C_HOLD, C_CLR, C_LDC, C_ADD, C_DEC});
    endfunction
    always @(negedge Clk)
        if (armed)
            for (int i = 0; i < 2; i++) begin
                bcnt[i] = busy[i] ? bcnt[i] + 1 : 0;
                hcnt[i] = !busy[i] ? 0 : (rdy[i] && vld[i]) ? hcnt[i] + 1 : hcnt[i];
                chk("ctrl_code_legal", legal(ctrl[i]), 1);
                if (rdy[i] && !vld[i]) chk("stall_ctrl_hold", ctrl[i], C_HOLD);
                if (!busy[i]) chk("idle_ctrl_hold", ctrl[i], C_HOLD);
                if (done[i] || err[i]) begin
                    if (sb.size() == 0) begin
                        compared++;
                        failed++;
                        $display("FAIL unexpected_pulse: inst %0d done %0d err %0d with no job expected", i, done[i], err[i]);
                    end else begin
                        e = sb.pop_front();
                        chk("instance", i, e.inst);
                        chk("err_pulse", err[i], e.is_err);
                        chk("done_pulse", done[i], !e.is_err);
                        chk("acc_out", acc_m[i], e.sum);
                        chk("busy_cycles_to_end", bcnt[i], e.lat);
                        chk("handshakes", hcnt[i], e.hs);
                    end
                end
            end
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask
    task automatic wait_rdy();
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!rdy[sel] && n < 100);
        chk("ready_seen", rdy[sel], 1);
    endtask
    task automatic send(input logic [7:0] w, input int stall);
        if (stall > 0) begin
            valid = 0;
            wait_rdy();
            repeat (stall - 1) @(negedge Clk);
            tick();
        end
        valid = 1;
        data = w;
        wait_rdy();
        tick();
        valid = 0;
    endtask
    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask
    task automatic wait_end(input int inst, input bit want_err);
        int n = 0;
        while (!(want_err ? err[inst] : done[inst]) && n < 300) begin
            @(negedge Clk);
            n++;
        end
        chk(want_err ? "err_seen" : "done_seen", want_err ? err[inst] : done[inst], 1);
        tick();
    endtask
    task automatic job(input int inst, input int stall, input int lat, input logic [7:0] sum, input bit poke);
        sb.push_back('{inst, 1'b0, sum, lat, words.size()});
        sel = inst[0];
        pulse_start();
        foreach (words[k]) begin
            send(words[k], k == 0 ? 0 : stall);
            if (poke && k == 0) pulse_start();
        end
        wait_end(inst, 0);
    endtask
    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_ctrl"}, ctrl[i], C_HOLD);
            chk({tag, "_ready"}, rdy[i], 0);
            chk({tag, "_busy"}, busy[i], 0);
            chk({tag, "_done"}, done[i], 0);
            chk({tag, "_err"}, err[i], 0);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) tick();
        check_idle("reset");
        Reset = 0;
        armed = 1;
        tick();
        check_idle("post_reset");
        words = '{8'd3, 8'd5, 8'd7, 8'd9};
        job(0, 0, 13, 8'd21, 0);
        words = '{8'd0};
        job(0, 0, 4, 8'd0, 0);
        words = '{8'd2, 8'd200, 8'd100};
        job(0, 0, 10, 8'd44, 0);
        words = '{8'd2, 8'd10, 8'd20};
        job(0, 5, 20, 8'd30, 0);
        // Timeout instance: count 1, then the source goes silent for good.
        sb.push_back('{1, 1'b1, 8'd0, 8, 1});
        sel = 1;
        pulse_start();
        send(8'd1, 0);
        wait_end(1, 1);
        chk("idle_after_err", busy[1], 0);
        words = '{8'd1, 8'd6};
        job(1, 0, 7, 8'd6, 0);
        // Reset while the count-5 job sits in DEC.
        sel = 0;
        pulse_start();
        valid = 1;
        data = 8'd5;
        wait_rdy();
        tick();
        data = 8'd1;
        for (int n = 0; n < 50 && ctrl[0] != C_DEC; n++) @(negedge Clk);
        chk("dec_reached", ctrl[0], C_DEC);
        Reset = 1;
        tick();
        chk("reset_mid_ctrl", ctrl[0], C_HOLD);
        chk("reset_mid_busy", busy[0], 0);
        chk("reset_mid_ready", rdy[0], 0);
        Reset = 0;
        valid = 0;
        tick();
        words = '{8'd1, 8'd4};
        job(0, 0, 7, 8'd4, 1);
        repeat (3) begin
            @(negedge Clk);
            chk("stay_idle_after_ignored_start", busy[0], 0);
        end
        repeat (2) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
